// File: rtl/arb_pkg.sv
// Shared arbitration types and the generic round-robin search helper.
package arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_e;

    localparam int unsigned RR_MAX_N = 32;

    // Index of the first set bit of vec[n-1:0] at or after start, wrapping around.
    // Doubling the vector turns the wrap into a plain borrow chain for the subtract.
    function automatic int unsigned rr_first(input logic [RR_MAX_N-1:0] vec,
                                             input int unsigned start,
                                             input int unsigned n = RR_MAX_N);
        logic [2*RR_MAX_N-1:0] dbl;
        logic [2*RR_MAX_N-1:0] base;
        logic [2*RR_MAX_N-1:0] win;
        int unsigned           idx;
        dbl  = '0;
        base = '0;
        idx  = 0;
        for (int unsigned i = 0; i < RR_MAX_N; i++) begin
            if (i < n) begin
                dbl[i]     = vec[i];
                dbl[i + n] = vec[i];
            end
        end
        base[start] = 1'b1;
        win = dbl & ~(dbl - base);
        for (int unsigned i = 0; i < 2 * RR_MAX_N; i++) begin
            if (win[i]) idx = (i >= n) ? i - n : i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first request at or after the one-hot start mask.
module rr_pick #(
    parameter  int N   = 4,
    localparam int IDW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]   req,
    input  logic [N-1:0]   start,
    output logic [N-1:0]   winner,
    output logic [IDW-1:0] idx
);

    logic [2*N-1:0] dbl;
    logic [2*N-1:0] win_dbl;

    always_comb begin
        dbl     = {req, req};
        // Borrow ripples from start up to the first set bit, isolating it.
        win_dbl = dbl & ~(dbl - {{N{1'b0}}, start});
        winner  = win_dbl[N-1:0] | win_dbl[2*N-1:N];
        idx     = '0;
        for (int i = 0; i < N; i++) begin
            if (winner[i]) idx = IDW'(i);
        end
    end

endmodule

// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter: registered one-hot grant held for up to weight beats.
module wrr_arbiter
    import arb_pkg::*;
#(
    parameter  int N   = 5,
    parameter  int W   = 4,
    localparam int IDW = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    input  logic [N*W-1:0]   weight,
    output logic [N-1:0]     grant,
    output logic [IDW-1:0]   grant_id,
    output logic             busy
);

    arb_state_e     state, state_nxt;
    logic [W-1:0]   credit, credit_nxt;
    logic [IDW-1:0] last, last_nxt;
    logic [IDW-1:0] start_idx, pick_idx, grant_id_nxt;
    logic [N-1:0]   start_mask, pick_oh, grant_nxt;
    logic           rearb;

    function automatic logic [W-1:0] floor_one(input logic [W-1:0] w);
        return (w == '0) ? W'(1) : w;
    endfunction

    always_comb begin
        start_idx             = (last == IDW'(N - 1)) ? '0 : last + IDW'(1);
        start_mask            = '0;
        start_mask[start_idx] = 1'b1;
    end

    rr_pick #(.N(N)) u_pick (
        .req    (req),
        .start  (start_mask),
        .winner (pick_oh),
        .idx    (pick_idx)
    );

    always_comb begin
        state_nxt    = state;
        credit_nxt   = credit;
        last_nxt     = last;
        grant_nxt    = grant;
        grant_id_nxt = grant_id;
        rearb        = (state == IDLE) || !req[grant_id] || (credit == W'(1));
        if (!rearb) begin
            credit_nxt = credit - W'(1);
        end else if (|req) begin
            // Start of a new tenure: the only point where weight is sampled.
            state_nxt    = OWN;
            grant_nxt    = pick_oh;
            grant_id_nxt = pick_idx;
            last_nxt     = pick_idx;
            credit_nxt   = floor_one(weight[int'(pick_idx)*W +: W]);
        end else begin
            state_nxt    = IDLE;
            grant_nxt    = '0;
            grant_id_nxt = '0;
            credit_nxt   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            credit   <= '0;
            last     <= IDW'(N - 1);
            grant    <= '0;
            grant_id <= '0;
            busy     <= 1'b0;
        end else begin
            state    <= state_nxt;
            credit   <= credit_nxt;
            last     <= last_nxt;
            grant    <= grant_nxt;
            grant_id <= grant_id_nxt;
            busy     <= |grant_nxt;
        end
    end

endmodule

// File: tb/tb_wrr_arbiter.sv
// Self-checking bench for wrr_arbiter (N=4, W=3): vector table, directed corners, random vs model.
module tb_wrr_arbiter;

    localparam int N = 4;
    localparam int W = 3;

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   req;
    logic [N*W-1:0] weight;
    logic [N-1:0]   grant;
    logic [1:0]     grant_id;
    logic           busy;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    bit m_busy;
    int m_owner;
    int m_credit;
    int m_last;

    typedef struct {
        logic [3:0]  req;
        logic [11:0] wt;
        logic [3:0]  exp_grant;
        logic [1:0]  exp_id;
    } vec_t;

    vec_t tbl[13];

    wrr_arbiter #(.N(N), .W(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .weight   (weight),
        .grant    (grant),
        .grant_id (grant_id),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy   = 1'b0;
        m_owner  = 0;
        m_credit = 0;
        m_last   = N - 1;
    endtask

    task automatic model_step(input logic [3:0] r, input logic [11:0] w);
        bit rearb;
        bit found;
        int c;
        int wt;
        rearb = !m_busy || !r[m_owner] || (m_credit == 1);
        if (!rearb) begin
            m_credit = m_credit - 1;
        end else if (r == 4'b0) begin
            m_busy = 1'b0;
        end else begin
            found = 1'b0;
            c     = 0;
            for (int j = 1; j <= N; j++) begin
                if (!found && r[(m_last + j) % N]) begin
                    found = 1'b1;
                    c     = (m_last + j) % N;
                end
            end
            wt       = int'(w[c*W +: W]);
            m_owner  = c;
            m_last   = c;
            m_busy   = 1'b1;
            m_credit = (wt == 0) ? 1 : wt;
        end
    endtask

    task automatic step(input logic [3:0] r, input logic [11:0] w);
        logic [3:0] eg;
        req    = r;
        weight = w;
        @(posedge clk);
        model_step(r, w);
        #1;
        eg = m_busy ? (4'b0001 << m_owner) : 4'b0000;
        chk("model_grant", grant, eg);
        chk("model_grant_id", grant_id, m_busy ? m_owner : 0);
        chk("model_busy", busy, m_busy);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        model_reset();
        #2;
        chk("rst_grant", grant, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_busy", busy, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [11:0] w0, wr;
        logic [3:0]  rr;
        rst_n  = 1'b0;
        req    = '0;
        weight = '0;

        // Weights for requesters 3..0 = {3,1,2,0}
        w0 = {3'd3, 3'd1, 3'd2, 3'd0};
        tbl[0]  = '{4'b0000, w0, 4'b0000, 2'd0};
        tbl[1]  = '{4'b0001, w0, 4'b0001, 2'd0};
        tbl[2]  = '{4'b1111, w0, 4'b0010, 2'd1};
        tbl[3]  = '{4'b1111, w0, 4'b0010, 2'd1};
        tbl[4]  = '{4'b1111, w0, 4'b0100, 2'd2};
        tbl[5]  = '{4'b1111, w0, 4'b1000, 2'd3};
        tbl[6]  = '{4'b1111, w0, 4'b1000, 2'd3};
        tbl[7]  = '{4'b1111, w0, 4'b1000, 2'd3};
        tbl[8]  = '{4'b1111, w0, 4'b0001, 2'd0};
        tbl[9]  = '{4'b1111, w0, 4'b0010, 2'd1};
        tbl[10] = '{4'b1111, w0, 4'b0010, 2'd1};
        tbl[11] = '{4'b1111, w0, 4'b0100, 2'd2};
        tbl[12] = '{4'b1111, w0, 4'b1000, 2'd3};

        do_reset();
        for (int i = 0; i < 13; i++) begin
            step(tbl[i].req, tbl[i].wt);
            chk($sformatf("tbl_grant[%0d]", i), grant, tbl[i].exp_grant);
            chk($sformatf("tbl_id[%0d]", i), grant_id, tbl[i].exp_id);
        end

        // Early release: requester 0 weight 5, requester 2 weight 3
        do_reset();
        wr = {3'd0, 3'd3, 3'd0, 3'd5};
        step(4'b0101, wr); chk("er_beat1", grant, 4'b0001);
        step(4'b0101, wr); chk("er_beat2", grant, 4'b0001);
        step(4'b0100, wr); chk("er_handover", grant, 4'b0100);
        step(4'b0101, wr); chk("er_r2_beat2", grant, 4'b0100);
        step(4'b0101, wr); chk("er_r2_beat3", grant, 4'b0100);
        step(4'b0101, wr); chk("er_back_to_0", grant, 4'b0001);

        // Sole requester keeps a continuous grant across credit reloads
        do_reset();
        wr = {3'd0, 3'd0, 3'd2, 3'd0};
        for (int i = 0; i < 12; i++) begin
            step(4'b0010, wr);
            chk("sole_grant", grant, 4'b0010);
            chk("sole_busy", busy, 1'b1);
        end

        // No pre-emption, then fairness from last=1
        do_reset();
        wr = {3'd4, 3'd0, 3'd0, 3'd0};
        step(4'b1000, wr); chk("np_beat1", grant, 4'b1000);
        for (int i = 2; i <= 4; i++) begin
            step(4'b1010, wr); chk("np_hold", grant, 4'b1000);
        end
        step(4'b1010, wr); chk("np_to_1", grant, 4'b0010);
        step(4'b1111, wr); chk("np_fair_2", grant, 4'b0100);

        // Asynchronous reset in the middle of a 3-beat tenure
        do_reset();
        wr = {3'd0, 3'd0, 3'd0, 3'd3};
        step(4'b0001, wr); chk("mr_beat1", grant, 4'b0001);
        step(4'b0001, wr); chk("mr_beat2", grant, 4'b0001);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_async_grant", grant, 0);
        chk("mr_async_id", grant_id, 0);
        chk("mr_async_busy", busy, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(4'b1111, wr); chk("mr_after", grant, 4'b0001);

        // Randomised traffic against the model
        do_reset();
        rr = '0;
        wr = 12'($urandom);
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) != 0) rr = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) wr = 12'($urandom);
            step(rr, wr);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
